// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux4_arb_pkg : shared types and helpers for the 4-way round-robin arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_SWITCH = 2'd2
   } arb_state_t;

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if : request/grant bundle between requesters and arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if;

   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic       busy;

   modport master (
      output en,
      output req,
      input  gnt,
      input  sel,
      input  valid,
      input  busy
   );

   modport slave (
      input  en,
      input  req,
      output gnt,
      output sel,
      output valid,
      output busy
   );

endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick4 : combinational round-robin picker, searches last+1 .. last+4 mod 4
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [SEL_W-1:0] i_last,
   output logic [SEL_W-1:0] o_pick,
   output logic             o_any
);

   logic [SEL_W-1:0] w_idx;
   logic             w_found;

   // The 2-bit index wraps naturally, so k=4 lands back on i_last itself.
   always_comb begin
      o_pick  = i_last;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = i_last + SEL_W'(k);
         if (!w_found && i_req[w_idx]) begin
            o_pick  = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux4_rr_arbiter : time-sliced round-robin owner of the 4:1 mux select
// Revision 1.0
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int SLICE_CYCLES = 8,
   parameter int CNT_W        = 8
)(
   input  logic               clk,
   input  logic               rst,
   mux4_rr_arbiter_if.slave   arb
);

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SLICE_CYCLES - 1);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [SEL_W-1:0] r_last;
   logic [SEL_W-1:0] w_last_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nxt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] w_gnt_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic [SEL_W-1:0] w_pick;
   logic             w_any;
   logic             w_release;
   logic             w_preempt;
   logic             w_exit;

   rr_pick4 u_pick (
      .i_req  (arb.req),
      .i_last (r_last),
      .o_pick (w_pick),
      .o_any  (w_any)
   );

   assign w_release = ~arb.req[r_sel];
   assign w_preempt = (r_cnt == c_CNT_LAST) && ((arb.req & ~r_gnt) != '0);
   assign w_exit    = w_release | w_preempt | ~arb.en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_last  <= 2'd3;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_gnt_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (arb.en && w_any) begin
               w_state_nxt = ST_GRANT;
               w_sel_nxt   = w_pick;
               w_cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            if (w_exit) begin
               w_state_nxt = ST_SWITCH;
               w_last_nxt  = onehot_to_idx(r_gnt);
               w_cnt_nxt   = '0;
            end else if (r_cnt != c_CNT_LAST) begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         ST_SWITCH: begin
            // r_last already holds the outgoing owner, so the picker rotates past it.
            if (arb.en && w_any) begin
               w_state_nxt = ST_GRANT;
               w_sel_nxt   = w_pick;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they land in registers.
   always_comb begin
      w_gnt_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      if (w_state_nxt == ST_GRANT) begin
         w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel_nxt;
         w_valid_nxt = 1'b1;
      end
   end

   assign arb.gnt   = r_gnt;
   assign arb.sel   = r_sel;
   assign arb.valid = r_valid;
   assign arb.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter : directed table and sequence checks for mux4_rr_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux4_rr_arbiter_if bus8();
   mux4_rr_arbiter_if bus1();

   mux4_rr_arbiter #(.SLICE_CYCLES(8), .CNT_W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .arb (bus8)
   );

   mux4_rr_arbiter #(.SLICE_CYCLES(1), .CNT_W(8)) dut1 (
      .clk (clk),
      .rst (rst),
      .arb (bus1)
   );

   typedef struct {
      logic       en;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       busy;
   } vec_t;

   localparam int N_VEC = 22;
   vec_t tbl [N_VEC];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ex(input logic [3:0] g, input logic [1:0] s,
                                     input logic v, input logic b);
      return {g, s, v, b};
   endfunction

   function automatic logic [7:0] obs8();
      return {bus8.gnt, bus8.sel, bus8.valid, bus8.busy};
   endfunction

   function automatic logic [7:0] obs1();
      return {bus1.gnt, bus1.sel, bus1.valid, bus1.busy};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {gnt,sel,valid,busy}=%b required %b", name, act, exp);
      end
   endtask

   initial begin
      logic [1:0] o;
      logic [3:0] g;
      int         nvalid;

      // {en, req, gnt, sel, valid, busy}; starts from reset, last owner = 3
      tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 4'b0011, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 4'b0011, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1};
      tbl[12] = '{1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 4'b0001, 4'b0000, 2'd1, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
      tbl[15] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
      tbl[18] = '{1'b1, 4'b0100, 4'b0000, 2'd1, 1'b0, 1'b1};
      tbl[19] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
      tbl[20] = '{1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1};
      tbl[21] = '{1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};

      bus8.en  = 1'b0;
      bus8.req = 4'b0000;
      bus1.en  = 1'b0;
      bus1.req = 4'b0000;

      step();
      step();
      chk("reset_dut8", obs8(), ex(4'b0000, 2'd0, 1'b0, 1'b0));
      chk("reset_dut1", obs1(), ex(4'b0000, 2'd0, 1'b0, 1'b0));
      rst = 1'b0;

      for (int i = 0; i < N_VEC; i++) begin
         bus8.en  = tbl[i].en;
         bus8.req = tbl[i].req;
         step();
         chk($sformatf("vec%0d", i), obs8(),
             ex(tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].busy));
      end

      // All four requesting: 8-cycle slices with a 1-cycle gap, owners 0,1,2,3,0
      bus8.en  = 1'b1;
      bus8.req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         o = 2'(r % 4);
         g = 4'b0001 << o;
         for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("rot_owner%0d_cyc%0d", o, c), obs8(), ex(g, o, 1'b1, 1'b1));
         end
         if (r == 4) bus8.req = 4'b0000;
         step();
         chk($sformatf("rot_gap_after%0d", o), obs8(), ex(4'b0000, o, 1'b0, 1'b1));
      end
      step();
      chk("rot_idle", obs8(), ex(4'b0000, 2'd0, 1'b0, 1'b0));

      // Lone requester keeps the grant past its slice, then yields to a newcomer
      bus8.req = 4'b0010;
      for (int c = 0; c < 20; c++) begin
         step();
         chk($sformatf("solo_cyc%0d", c), obs8(), ex(4'b0010, 2'd1, 1'b1, 1'b1));
      end
      bus8.req = 4'b1010;
      step();
      chk("solo_preempt_gap", obs8(), ex(4'b0000, 2'd1, 1'b0, 1'b1));
      step();
      chk("solo_new_owner", obs8(), ex(4'b1000, 2'd3, 1'b1, 1'b1));
      bus8.req = 4'b0000;
      step();
      chk("solo_release", obs8(), ex(4'b0000, 2'd3, 1'b0, 1'b1));
      step();
      chk("solo_idle", obs8(), ex(4'b0000, 2'd3, 1'b0, 1'b0));

      // Asynchronous reset in the middle of owner 2's grant
      bus8.req = 4'b0100;
      step();
      chk("pre_rst_grant", obs8(), ex(4'b0100, 2'd2, 1'b1, 1'b1));
      step();
      rst = 1'b1;
      #1;
      chk("async_rst_drop", obs8(), ex(4'b0000, 2'd0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus8.req = 4'b1111;
      step();
      chk("post_rst_first", obs8(), ex(4'b0001, 2'd0, 1'b1, 1'b1));
      bus8.req = 4'b0000;
      step();
      chk("post_rst_release", obs8(), ex(4'b0000, 2'd0, 1'b0, 1'b1));
      step();
      chk("post_rst_idle", obs8(), ex(4'b0000, 2'd0, 1'b0, 1'b0));

      // Disabled arbiter ignores requests
      bus8.en  = 1'b0;
      bus8.req = 4'b0011;
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("en_low_cyc%0d", c), obs8(), ex(4'b0000, 2'd0, 1'b0, 1'b0));
      end
      bus8.req = 4'b0000;

      // One-cycle slices on the second instance: 1, gap, 3, gap, ...
      bus1.en  = 1'b1;
      bus1.req = 4'b1010;
      nvalid   = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         case (c % 4)
            0:       chk($sformatf("s1_cyc%0d", c), obs1(), ex(4'b0010, 2'd1, 1'b1, 1'b1));
            1:       chk($sformatf("s1_cyc%0d", c), obs1(), ex(4'b0000, 2'd1, 1'b0, 1'b1));
            2:       chk($sformatf("s1_cyc%0d", c), obs1(), ex(4'b1000, 2'd3, 1'b1, 1'b1));
            default: chk($sformatf("s1_cyc%0d", c), obs1(), ex(4'b0000, 2'd3, 1'b0, 1'b1));
         endcase
         if (bus1.valid === 1'b1) nvalid++;
      end
      chk("s1_valid_duty", 8'(nvalid), 8'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
